// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, control bundle, defaults.
// Latency: n/a (types and constants only). Backpressure: n/a.
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 32;

    localparam logic [REG_AW_DEF-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
        logic halted;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET    = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1, halted: 1'b0};
    localparam ctrl_t CTRL_NORMAL   = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, halted: 1'b0};
    localparam ctrl_t CTRL_REDIRECT = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1, halted: 1'b0};
    localparam ctrl_t CTRL_STALL    = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1, halted: 1'b0};
    localparam ctrl_t CTRL_DRAIN    = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0, halted: 1'b0};
    localparam ctrl_t CTRL_HALTED   = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1, halted: 1'b1};

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: load-use comparator between the ID sources and the EX load destination.
// Latency: purely combinational. Backpressure: none; the result feeds the stall decision.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] ex_rw,
    input  logic              ex_load,
    output logic              lu
);

    logic rs_hit;
    logic rt_hit;
    logic rw_live;

    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign rw_live = (ex_rw != REG_AW'(ZERO_REG));
    assign rs_hit  = id_use_rs && (id_rs == ex_rw);
    assign rt_hit  = id_use_rt && (id_rt == ex_rw);
    assign lu      = ex_load && rw_live && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: PC / IF-ID / ID-EX enable and bubble sequencing, halt drain/resume; counters under PIPE_CTRL_STATS_EN.
// Latency: controls are combinational from current inputs and state, taking effect at the next clk edge.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle; a halt parks fetch until go.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_halt,
    input  logic [REG_AW-1:0] ex_rw,
    input  logic              ex_load,
    input  logic              ex_redirect,
    input  logic              wb_halt,
    input  logic              go,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  cycle_cnt
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   lu;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .ex_rw     (ex_rw),
        .ex_load   (ex_load),
        .lu        (lu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctrl      = CTRL_RESET;
        if (rst) begin
            state_nxt = RUN;
            ctrl      = CTRL_RESET;
        end else begin
            case (state)
                RUN: begin
                    // A taken redirect kills the wrong-path ID slot, including any hazard or halt it holds.
                    if (ex_redirect) begin
                        ctrl = CTRL_REDIRECT;
                    end else if (lu) begin
                        ctrl = CTRL_STALL;
                    end else if (id_halt) begin
                        ctrl      = CTRL_DRAIN;
                        state_nxt = DRAIN;
                    end else begin
                        ctrl = CTRL_NORMAL;
                    end
                end
                DRAIN: begin
                    // Everything older than the halt has resolved, so redirects are ignored here.
                    ctrl = CTRL_DRAIN;
                    if (wb_halt) begin
                        state_nxt = HALTED;
                    end
                end
                HALTED: begin
                    ctrl = CTRL_HALTED;
                    if (go) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    ctrl      = CTRL_RESET;
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;
    assign halted     = ctrl.halted;

`ifdef PIPE_CTRL_STATS_EN
    logic             stall_ev;
    logic             flush_ev;
    logic             cycle_ev;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] cycle_q;

    assign stall_ev = (state == RUN) && lu && !ex_redirect;
    assign flush_ev = (state == RUN) && ex_redirect;
    assign cycle_ev = (state != HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
            cycle_q <= '0;
        end else begin
            if (stall_ev) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_ev) begin
                flush_q <= flush_q + CNT_W'(1);
            end
            if (cycle_ev) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
    assign cycle_cnt = cycle_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: hazards, redirects, halt drain/resume, reset.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W = 32;
`ifdef PIPE_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]       ctrl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic [CNT_W-1:0] cycle;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_halt;
    logic [4:0]       ex_rw;
    logic             ex_load;
    logic             ex_redirect;
    logic             wb_halt;
    logic             go;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] cycle_cnt;

    exp_t        sb[$];
    int          n_assert;
    int          n_fail;
    int unsigned m_stall;
    int unsigned m_flush;
    int unsigned m_cycle;

    pipe_ctrl #(
        .REG_AW (5),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_halt     (id_halt),
        .ex_rw       (ex_rw),
        .ex_load     (ex_load),
        .ex_redirect (ex_redirect),
        .wb_halt     (wb_halt),
        .go          (go),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .cycle_cnt   (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag);
        exp_t       e;
        logic [4:0] obs;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s scoreboard: queue size %0d, required nonzero", tag, sb.size());
        end
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {pc_en, ifid_en, ifid_flush, idex_flush, halted};
            n_assert++;
            assert (obs === e.ctrl) else begin
                n_fail++;
                $error("FAIL %s ctrl{pc,ifid_en,ifid_fl,idex_fl,halted}: got %b, required %b", tag, obs, e.ctrl);
            end
            n_assert++;
            assert (stall_cnt === e.stall) else begin
                n_fail++;
                $error("FAIL %s stall_cnt: got %0d, required %0d", tag, stall_cnt, e.stall);
            end
            n_assert++;
            assert (flush_cnt === e.flush) else begin
                n_fail++;
                $error("FAIL %s flush_cnt: got %0d, required %0d", tag, flush_cnt, e.flush);
            end
            n_assert++;
            assert (cycle_cnt === e.cycle) else begin
                n_fail++;
                $error("FAIL %s cycle_cnt: got %0d, required %0d", tag, cycle_cnt, e.cycle);
            end
        end
    endtask

    // One clock cycle: drive inputs, queue the expected outputs, compare at negedge,
    // then advance the expected counters according to what this cycle should count.
    task automatic step(input string tag, input logic r,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic ih,
                        input logic [4:0] rw, input logic ld, input logic rd,
                        input logic wh, input logic g,
                        input logic [4:0] exp_ctrl, input logic si, input logic fi);
        exp_t e;
        rst         = r;
        id_rs       = rs;
        id_rt       = rt;
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_halt     = ih;
        ex_rw       = rw;
        ex_load     = ld;
        ex_redirect = rd;
        wb_halt     = wh;
        go          = g;
        e.ctrl  = exp_ctrl;
        e.stall = STATS ? CNT_W'(m_stall) : '0;
        e.flush = STATS ? CNT_W'(m_flush) : '0;
        e.cycle = STATS ? CNT_W'(m_cycle) : '0;
        sb.push_back(e);
        @(negedge clk);
        check(tag);
        @(posedge clk);
        #1;
        if (r) begin
            m_stall = 0;
            m_flush = 0;
            m_cycle = 0;
        end else begin
            if (si) m_stall++;
            if (fi) m_flush++;
            if (!exp_ctrl[0]) m_cycle++;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_stall  = 0;
        m_flush  = 0;
        m_cycle  = 0;
        rst = 1'b1; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_halt = 1'b0;
        ex_rw = '0; ex_load = 1'b0; ex_redirect = 1'b0; wb_halt = 1'b0; go = 1'b0;
        @(posedge clk);
        #1;
        // ctrl order: pc_en, ifid_en, ifid_flush, idex_flush, halted
        //      tag           rst rs    rt    urs  urt  ih   rw    ld   rd   wh   g    ctrl      si   fi
        step("reset",        1, 5'd0, 5'd0, 0,   0,   0,   5'd0, 0,   0,   0,   0,   5'b00110, 0,   0);
        step("run_idle",     0, 5'd1, 5'd2, 1,   1,   0,   5'd3, 0,   0,   0,   0,   5'b11000, 0,   0);
        step("lu_rs",        0, 5'd8, 5'd2, 1,   1,   0,   5'd8, 1,   0,   0,   0,   5'b00010, 1,   0);
        step("after_lu",     0, 5'd8, 5'd2, 1,   1,   0,   5'd0, 0,   0,   0,   0,   5'b11000, 0,   0);
        step("load_r0",      0, 5'd0, 5'd0, 1,   1,   0,   5'd0, 1,   0,   0,   0,   5'b11000, 0,   0);
        step("lu_rt",        0, 5'd3, 5'd9, 0,   1,   0,   5'd9, 1,   0,   0,   0,   5'b00010, 1,   0);
        step("rt_unused",    0, 5'd3, 5'd9, 1,   0,   0,   5'd9, 1,   0,   0,   0,   5'b11000, 0,   0);
        step("redir_lu",     0, 5'd8, 5'd2, 1,   0,   0,   5'd8, 1,   1,   0,   0,   5'b11110, 0,   1);
        step("after_redir",  0, 5'd4, 5'd5, 1,   1,   0,   5'd6, 0,   0,   0,   0,   5'b11000, 0,   0);
        step("halt_wrong",   0, 5'd0, 5'd0, 0,   0,   1,   5'd0, 0,   1,   0,   0,   5'b11110, 0,   1);
        step("still_run",    0, 5'd4, 5'd5, 1,   1,   0,   5'd6, 0,   0,   0,   0,   5'b11000, 0,   0);
        step("halt_id",      0, 5'd0, 5'd0, 0,   0,   1,   5'd0, 0,   0,   0,   0,   5'b01100, 0,   0);
        step("drain1_noise", 0, 5'd0, 5'd0, 0,   0,   0,   5'd0, 0,   1,   0,   1,   5'b01100, 0,   0);
        step("drain2",       0, 5'd0, 5'd0, 0,   0,   0,   5'd0, 0,   0,   0,   0,   5'b01100, 0,   0);
        step("drain3_wb",    0, 5'd0, 5'd0, 0,   0,   0,   5'd0, 0,   0,   1,   0,   5'b01100, 0,   0);
        step("halted",       0, 5'd8, 5'd0, 1,   0,   0,   5'd8, 1,   0,   0,   0,   5'b00011, 0,   0);
        step("halted_go",    0, 5'd0, 5'd0, 0,   0,   0,   5'd0, 0,   0,   0,   1,   5'b00011, 0,   0);
        step("resumed",      0, 5'd1, 5'd2, 1,   1,   0,   5'd3, 0,   0,   0,   0,   5'b11000, 0,   0);
        step("halt_id2",     0, 5'd0, 5'd0, 0,   0,   1,   5'd0, 0,   0,   0,   0,   5'b01100, 0,   0);
        step("drain_wb_go",  0, 5'd0, 5'd0, 0,   0,   0,   5'd0, 0,   0,   1,   1,   5'b01100, 0,   0);
        step("go_not_kept",  0, 5'd0, 5'd0, 0,   0,   0,   5'd0, 0,   0,   0,   0,   5'b00011, 0,   0);
        step("halted_go2",   0, 5'd0, 5'd0, 0,   0,   0,   5'd0, 0,   0,   0,   1,   5'b00011, 0,   0);
        step("halt_id3",     0, 5'd0, 5'd0, 0,   0,   1,   5'd0, 0,   0,   0,   0,   5'b01100, 0,   0);
        step("rst_in_drain", 1, 5'd0, 5'd0, 0,   0,   0,   5'd0, 0,   0,   1,   1,   5'b00110, 0,   0);
        step("post_reset",   0, 5'd1, 5'd2, 1,   1,   0,   5'd3, 0,   0,   0,   0,   5'b11000, 0,   0);
        step("lu_over_halt", 0, 5'd8, 5'd0, 1,   0,   1,   5'd8, 1,   0,   0,   0,   5'b00010, 1,   0);
        step("run_final",    0, 5'd1, 5'd2, 1,   1,   0,   5'd3, 0,   0,   0,   0,   5'b11000, 0,   0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
